mips_multicycle: RTL
====================

// Module: mips_multicycle
// PURPOSE
//  Multicycle MIPS-subset core with one unified instruction/data memory port and a req/ready handshake.
//  Successor to the single-cycle core: reuses one ALU and one memory across states, tolerates
//  variable memory latency, has a parametrised reset vector and flags illegal instructions.
//  Sits at the top of the CPU, between the SoC memory system and the debug/retire monitors.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset.
//  ADDR_W    32             Width of mem_addr, driven from the low ADDR_W bits of the byte address.
// PORTS
//  clk         in   1       Rising-edge clock; the only clock.
//  reset       in   1       Asynchronous, active-low reset.
//  mem_req     out  1       Memory access request.
//  mem_we      out  1       1 = write, 0 = read; meaningful only while mem_req=1.
//  mem_addr    out  ADDR_W  Byte address; always word-aligned.
//  mem_wdata   out  32      Store data.
//  mem_rdata   in   32      Read data; valid in the cycle mem_req&&mem_ready&&!mem_we.
//  mem_ready   in   1       Transfer completes in any cycle where mem_req&&mem_ready.
//  pc          out  32      Current PC.
//  retire      out  1       One-cycle pulse in the final state of each completed instruction.
//  illegal     out  1       Sticky; set on an unsupported opcode or funct. The core then halts.
// BEHAVIOUR
//  Reset (reset=0, asynchronous): pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, retire=0, illegal=0.
//   IR, A, B, ALUOut, MDR and all 32 registers clear to 0.
//   Reset asserted mid-transfer drops mem_req immediately. The aborted access is not retried.
//  Handshake: once mem_req=1, mem_addr, mem_we and mem_wdata stay stable until the completing cycle.
//   mem_req stays high through wait cycles (mem_ready=0). No other state advances during waits.
//  ISA: R-type add/sub/and/or/slt (op 0, funct 20/22/24/25/2A hex); lw 23; sw 2B; beq 04; addi 08; j 02.
//   Any other op, or op 0 with any other funct -> ILLEGAL.
//  FSM, one state per cycle unless memory waits:
//   FETCH     req rd @pc. On completion: IR<=rdata, pc<=pc+4, go to DECODE.
//   DECODE    A<=R[rs], B<=R[rt], ALUOut<=pc+(sext(imm)<<2). Dispatch on opcode.
//   MEMADR    ALUOut<=A+sext(imm). Go to MEMREAD (lw) or MEMWRITE (sw).
//   MEMREAD   req rd @ALUOut. On completion: MDR<=rdata, go to MEMWB.
//   MEMWB     R[rt]<=MDR, retire, go to FETCH.
//   MEMWRITE  req wr @ALUOut with wdata=B. On completion: retire, go to FETCH.
//   EXECUTE   ALUOut<=A op B, go to ALUWB.
//   ALUWB     R[rd]<=ALUOut, retire, go to FETCH.
//   ADDIEX    ALUOut<=A+sext(imm), go to ADDIWB.
//   ADDIWB    R[rt]<=ALUOut, retire, go to FETCH.
//   BRANCH    if A==B then pc<=ALUOut. Retire, go to FETCH.
//   JUMP      pc<={pc[31:28],IR[25:0],2'b00}. Retire, go to FETCH.
//   ILLEGAL   illegal=1, mem_req=0. Held until reset.
//  Zero-wait latency in cycles: R-type 4, addi 4, sw 4, lw 5, beq 3, j 3.
//   Each memory wait cycle adds one cycle.
//  Arithmetic: 32-bit two's complement. add/sub/addi wrap with no overflow trap. slt is a signed compare.
//  Register file: writes to $0 are discarded and $0 always reads 0.
//   Reads in DECODE see every write from earlier instructions.
//  pc wraps modulo 2^32. mem_addr[1:0] is always 2'b00: the low 2 bits of the computed address are ignored.
//  beq target is relative to pc+4, i.e. the pc after FETCH.
// TESTING
//  1. Zero-wait memory, program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,0($0); lw $4,0($0)
//     -> R3=2, mem[0]=2, R4=2; retire pulses at cycles 4,8,12,16,21 after reset release.
//  2. mem_ready low for 3 cycles on each fetch -> addr/we/wdata stable throughout; add completes in 7 cycles.
//  3. beq $1,$1,-1 (self loop) -> pc stays 0x0, retire every 3 cycles.
//     beq with A!=B -> pc=0x4.
//  4. sub $5,$0,$1 with R1=1 -> R5=0xFFFF_FFFF.
//     slt $6,$5,$0 -> R6=1.
//     addi $0,$0,7 -> R0 reads 0.
//  5. Fetch 0xFC00_0000 (op 3F) -> illegal=1 in the cycle after DECODE.
//     mem_req stays 0 and no retire until reset.
//  6. Assert reset during a waiting lw read -> mem_req=0 the same cycle.
//     After release, pc=RESET_PC and the first fetch is at RESET_PC.

Source files
------------

// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core: one shared ALU, one unified memory port with req/ready handshake.
// Supports add/sub/and/or/slt, lw, sw, beq, addi, j; anything else parks the core in ILLEGAL.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              illegal
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam logic [5:0]  OP_R   = 6'h00;
    localparam logic [5:0]  OP_LW  = 6'h23;
    localparam logic [5:0]  OP_SW  = 6'h2B;
    localparam logic [5:0]  OP_BEQ = 6'h04;
    localparam logic [5:0]  OP_ADDI = 6'h08;
    localparam logic [5:0]  OP_J   = 6'h02;
    localparam logic [5:0]  FN_ADD = 6'h20;
    localparam logic [5:0]  FN_SUB = 6'h22;
    localparam logic [5:0]  FN_AND = 6'h24;
    localparam logic [5:0]  FN_OR  = 6'h25;
    localparam logic [5:0]  FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE,
        ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ILLEGAL
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   ir, a, b, aluout, mdr;
    logic [XLEN-1:0]   ir_n, a_n, b_n, aluout_n, mdr_n, pc_n;
    logic [XLEN-1:0]   rf [NREGS];
    logic              req_n, we_n, illegal_n;
    logic [ADDR_W-1:0] addr_n;
    logic [XLEN-1:0]   wdata_n;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [XLEN-1:0]   rf_wd;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [XLEN-1:0]   imm_sx;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_sx = {{16{ir[15]}}, ir[15:0]};

    // Word-aligned memory address from a byte address.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
        return ADDR_W'({byte_addr[XLEN-1:2], 2'b00});
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
    endfunction

    // Combinational retire so a store retires exactly in its completing cycle.
    assign retire = (state == MEMWB) || (state == ALUWB) || (state == ADDIWB) ||
                    (state == BRANCH) || (state == JUMP) ||
                    ((state == MEMWRITE) && mem_req && mem_ready);

    // Next-state and datapath next values.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        a_n       = a;
        b_n       = b;
        aluout_n  = aluout;
        mdr_n     = mdr;
        req_n     = mem_req;
        we_n      = mem_we;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        illegal_n = illegal;
        rf_we     = 1'b0;
        rf_wa     = 5'd0;
        rf_wd     = '0;

        case (state)
            FETCH: begin
                if (!mem_req) begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = word_addr(pc);
                end else if (mem_ready) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc + 32'd4;
                    req_n   = 1'b0;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                a_n      = rf[rs];
                b_n      = rf[rt];
                aluout_n = pc + {imm_sx[XLEN-3:0], 2'b00};
                case (op)
                    OP_R:    state_n = funct_ok(funct) ? EXECUTE : ILLEGAL;
                    OP_LW,
                    OP_SW:   state_n = MEMADR;
                    OP_BEQ:  state_n = BRANCH;
                    OP_ADDI: state_n = ADDIEX;
                    OP_J:    state_n = JUMP;
                    default: state_n = ILLEGAL;
                endcase
                if (state_n == ILLEGAL) begin
                    illegal_n = 1'b1;
                end
            end
            MEMADR: begin
                aluout_n = a + imm_sx;
                req_n    = 1'b1;
                we_n     = (op == OP_SW);
                addr_n   = word_addr(a + imm_sx);
                wdata_n  = b;
                state_n  = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                if (mem_ready) begin
                    mdr_n   = mem_rdata;
                    req_n   = 1'b0;
                    state_n = MEMWB;
                end
            end
            MEMWB: begin
                rf_we   = 1'b1;
                rf_wa   = rt;
                rf_wd   = mdr;
                state_n = FETCH;
            end
            MEMWRITE: begin
                if (mem_ready) begin
                    state_n = FETCH;
                end
            end
            EXECUTE: begin
                case (funct)
                    FN_SUB:  aluout_n = a - b;
                    FN_AND:  aluout_n = a & b;
                    FN_OR:   aluout_n = a | b;
                    FN_SLT:  aluout_n = {31'd0, ($signed(a) < $signed(b))};
                    default: aluout_n = a + b;
                endcase
                state_n = ALUWB;
            end
            ALUWB: begin
                rf_we   = 1'b1;
                rf_wa   = rd;
                rf_wd   = aluout;
                state_n = FETCH;
            end
            ADDIEX: begin
                aluout_n = a + imm_sx;
                state_n  = ADDIWB;
            end
            ADDIWB: begin
                rf_we   = 1'b1;
                rf_wa   = rt;
                rf_wd   = aluout;
                state_n = FETCH;
            end
            BRANCH: begin
                if (a == b) begin
                    pc_n = aluout;
                end
                state_n = FETCH;
            end
            JUMP: begin
                pc_n    = {pc[31:28], ir[25:0], 2'b00};
                state_n = FETCH;
            end
            ILLEGAL: begin
                illegal_n = 1'b1;
                req_n     = 1'b0;
            end
            default: state_n = ILLEGAL;
        endcase

        // Entering FETCH from another state issues the instruction read right away.
        if ((state_n == FETCH) && (state != FETCH)) begin
            req_n  = 1'b1;
            we_n   = 1'b0;
            addr_n = word_addr(pc_n);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            aluout    <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            a         <= a_n;
            b         <= b_n;
            aluout    <= aluout_n;
            mdr       <= mdr_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            illegal   <= illegal_n;
        end
    end

    // Register file; $0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we && (rf_wa != 5'd0)) begin
            rf[rf_wa] <= rf_wd;
        end
    end
endmodule
